// File: rtl/readback_unpacker.sv
// Splits FIFO_WIDTH readback words into C_DATA_WIDTH AXI-Stream beats, MSB lane first.
// Optional: define READBACK_BEAT_COUNT_EN to add a 32-bit output handshake counter (beat_count).
module readback_unpacker #(
  parameter int C_DATA_WIDTH = 64,
  parameter int FIFO_WIDTH   = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FIFO_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
`ifdef READBACK_BEAT_COUNT_EN
  ,
  output logic [31:0]                  beat_count
`endif
);

  localparam int FIFO_SCALE = FIFO_WIDTH / C_DATA_WIDTH;
  localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;
  localparam int BEAT_W     = $clog2(FIFO_SCALE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FIFO_SCALE - 1);

  typedef enum logic {EMPTY = 1'b0, STREAM = 1'b1} state_e;

  state_e                                 state_q, state_d;
  logic [FIFO_WIDTH-1:0]                  hold_q, hold_d;
  logic                                   hold_last_q, hold_last_d;
  logic [BEAT_W-1:0]                      beat_q, beat_d;
  logic [FIFO_SCALE-1:0][C_DATA_WIDTH-1:0] lanes;
  logic                                   hold_valid, last_beat_go, m_hs, s_hs;

  assign hold_valid = (state_q == STREAM);
  assign lanes      = hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      beat_q      <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    beat_d      = beat_q;
    case (state_q)
      EMPTY: begin
        if (s_hs) begin
          hold_d      = s_axis_tdata;
          hold_last_d = s_axis_tlast;
          beat_d      = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (last_beat_go) begin
          beat_d = '0;
          // A new word can slip in on the cycle the last beat drains.
          if (s_hs) begin
            hold_d      = s_axis_tdata;
            hold_last_d = s_axis_tlast;
          end else begin
            state_d = EMPTY;
          end
        end else if (m_hs) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    m_hs          = hold_valid && m_axis_tready;
    last_beat_go  = m_hs && (beat_q == LAST_BEAT);
    s_axis_tready = !reset && (!hold_valid || last_beat_go);
    s_hs          = s_axis_tvalid && s_axis_tready;
    m_axis_tdata  = lanes[LAST_BEAT - beat_q];
    m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
    m_axis_tvalid = hold_valid;
    m_axis_tlast  = hold_valid && hold_last_q && (beat_q == LAST_BEAT);
  end

`ifdef READBACK_BEAT_COUNT_EN
  logic [31:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (m_hs) beat_count_d = beat_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) beat_count_q <= '0;
    else       beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: doc/readback_unpacker.md
# readback_unpacker

Serializes wide readback words (FIFO_WIDTH bits, produced by the DRAM read path and read-data FIFO) into a C_DATA_WIDTH AXI-Stream toward the host DMA/PCIe engine. It is the host-bound counterpart of the instruction packing path. Its beat order is the exact inverse of that packing: the most-significant 64 bits go out first, so a host word written as beat k lands back in beat k. It holds one wide word plus a beat counter and streams it at one beat per cycle under AXI-Stream backpressure.

## Interface
Parameters:
- C_DATA_WIDTH, 64, output beat width in bits; fixed at 64.
- FIFO_WIDTH, 256, input word width; integer multiple of C_DATA_WIDTH, ≥ 2×C_DATA_WIDTH.
- Derived (localparam): FIFO_SCALE = FIFO_WIDTH/C_DATA_WIDTH; KEEP_WIDTH = C_DATA_WIDTH/8.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  FIFO_WIDTH  wide readback word.
- s_axis_tvalid  in  1  wide word valid.
- s_axis_tready  out  1  wide word accepted when high with tvalid.
- s_axis_tlast  in  1  wide word ends a readback transfer.
- m_axis_tdata  out  C_DATA_WIDTH  output beat.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables; constant all-ones.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the transfer.
- beat_count  out  32  only with READBACK_BEAT_COUNT_EN; see Configuration.

## Operation
- State: hold_r (FIFO_WIDTH), hold_last_r, hold_valid_r, beat_r (clog2(FIFO_SCALE) bits). There are two states:
  - EMPTY: hold_valid_r = 0.
  - STREAM: hold_valid_r = 1.
- m_axis_tdata = hold_r[FIFO_WIDTH-1-beat_r*C_DATA_WIDTH -: C_DATA_WIDTH].
  - Beat 0 is bits [FIFO_WIDTH-1 -: 64].
  - Within a beat, the upper 32 bits carry the earlier 32-bit slot.
- m_axis_tvalid = hold_valid_r.
- m_axis_tlast = hold_valid_r && hold_last_r && (beat_r == FIFO_SCALE-1).
- m_axis_tkeep is all ones at all times, including in reset.
- last_beat_go = hold_valid_r && m_axis_tready && beat_r == FIFO_SCALE-1.
- s_axis_tready = !reset && (!hold_valid_r || last_beat_go). This is combinational from m_axis_tready, so a wide word is accepted on the same cycle the final beat drains.
- On an m_axis handshake that is not the last beat: beat_r increments.
- On last_beat_go:
  - If an s_axis handshake occurs the same cycle: load hold_r/hold_last_r, beat_r := 0, stay in STREAM.
  - Otherwise: hold_valid_r := 0, beat_r := 0, go to EMPTY.
- EMPTY with an s_axis handshake: load the word, beat_r := 0, go to STREAM.
- No m_axis handshake (m_axis_tready low): all state holds. m_axis_tdata, tvalid and tlast stay stable, as AXI-Stream requires.
- beat_r wraps only through the explicit reset to 0 on the last beat; it never counts past FIFO_SCALE-1.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, s_axis_tready = 0, m_axis_tdata = 0.
  - hold_r = 0, beat_r = 0, beat_count = 0.
- s_axis_tready rises in the first cycle after reset deasserts.
- Latency: wide word accepted at cycle N → beat 0 valid at N+1 → beat FIFO_SCALE-1 at N+FIFO_SCALE when m_axis_tready is held high.
- Throughput: with continuous input and m_axis_tready = 1, one beat per cycle with no bubbles between wide words. s_axis_tready is high one cycle in every FIFO_SCALE.
- Reset mid-word: the held word is discarded. m_axis_tvalid is 0 the cycle after reset is sampled. No partial tlast is emitted.
- Simultaneous last beat and a new wide word with tlast: m_axis_tlast follows the newly loaded hold_last_r only when its own last beat goes out.

## Configuration
- READBACK_BEAT_COUNT_EN defined:
  - Adds output beat_count[31:0], a register counting m_axis handshakes (tvalid && tready).
  - Increments by 1 per handshake and wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Not defined: the port and counter are absent. Datapath behaviour is identical either way.

## Test plan
- Single word: reset for 3 cycles, then send s_axis_tdata = 0x1111…_2222…_3333…_4444… (four 64-bit lanes, MSB lane first) with tlast = 1, m_axis_tready = 1.
  - Beats are 0x1111111111111111, 0x2222…, 0x3333…, 0x4444… on consecutive cycles, starting the cycle after acceptance.
  - tlast only on the 0x4444… beat; tkeep = 0xFF throughout.
- Back-to-back: three words with tvalid held high, tlast on the third only, m_axis_tready = 1.
  - 12 consecutive valid beats, no gap.
  - s_axis_tready pulses on cycles 0, 4 and 8 relative to first acceptance.
  - Exactly one tlast, on beat 12.
- Backpressure: drop m_axis_tready for 5 cycles while beat 1 is presented.
  - tdata, tvalid and tlast are unchanged during the stall and s_axis_tready = 0.
  - Streaming resumes with beat 1, then beat 2.
- Reset mid-word: assert reset for 1 cycle after beat 2 is accepted.
  - Next cycle m_axis_tvalid = 0 and no tlast appears.
  - A new word afterwards starts at beat 0.
- No tlast: one word with s_axis_tlast = 0 → four beats, m_axis_tlast never asserts.
- With READBACK_BEAT_COUNT_EN: stream 3 words.
  - beat_count = 12 afterwards; reset returns it to 0.
  - Preload via force to 0xFFFFFFFF; one handshake gives 0.
